// File: rtl/wb_byte_ram.sv
// Wishbone byte-lane-writable word RAM with programmable wait states (LATENCY).
// Optional feature: define WB_RAM_ERR_EN to add o_wb_err and out-of-range error responses.
module wb_byte_ram #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 1,
  parameter string       INIT_FILE  = ""
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [3:0]  i_wb_sel,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall
`ifdef WB_RAM_ERR_EN
  ,
  output logic        o_wb_err
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [31:0]     addr_q, data_q, rdata_q;
  logic [3:0]      sel_q;
  logic            we_q, ack_q, stall_q;
  logic            accept, access, oor;
  logic [31:0]     req_addr, req_data;
  logic [3:0]      req_sel;
  logic            req_we;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]     mem [2**ADDR_WIDTH];

  assign accept = i_wb_stb && !stall_q;

  // With zero wait states the access happens on the accepting edge, so the
  // live bus is used; otherwise the request captured at acceptance is used.
  assign req_addr = accept ? i_wb_addr : addr_q;
  assign req_data = accept ? i_wb_data : data_q;
  assign req_sel  = accept ? i_wb_sel  : sel_q;
  assign req_we   = accept ? i_wb_we   : we_q;
  assign idx      = req_addr[ADDR_WIDTH-1:0];

`ifdef WB_RAM_ERR_EN
  logic err_q;
  assign oor      = (req_addr >> ADDR_WIDTH) != 32'd0;
  assign o_wb_err = err_q;
`else
  logic unused_addr;
  assign oor         = 1'b0;
  assign unused_addr = ^req_addr;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (accept) begin
          state_d = (LATENCY == 0) ? RESP : WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign access = (state_d == RESP);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stall_q <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
`ifdef WB_RAM_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= (state_d == WAIT);
      ack_q   <= access && !oor;
`ifdef WB_RAM_ERR_EN
      err_q   <= access && oor;
`endif
      if (accept) begin
        addr_q <= i_wb_addr;
        data_q <= i_wb_data;
        sel_q  <= i_wb_sel;
        we_q   <= i_wb_we;
      end
      if (access && !req_we && !oor) rdata_q <= mem[idx];
    end
  end

  // Contents survive reset; the reset gate only blocks a commit during reset.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && access && req_we && !oor) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (req_sel[b]) mem[idx][8*b +: 8] <= req_data[8*b +: 8];
      end
    end
  end

  assign o_wb_data  = rdata_q;
  assign o_wb_ack   = ack_q;
  assign o_wb_stall = stall_q;

endmodule

// File: tb/tb_wb_byte_ram.sv
// Directed bench for wb_byte_ram: five instances at LATENCY 1, 0, 3, 15, 4.
`timescale 1ns/1ps
module tb_wb_byte_ram;

  localparam int NDUT = 5;

  logic        clk = 1'b0;
  logic [NDUT-1:0] rstn, stb, ack, stall;
  logic        wb_we;
  logic [31:0] wb_addr, wb_wdata;
  logic [3:0]  wb_sel;
  logic [31:0] rd [NDUT];
`ifdef WB_RAM_ERR_EN
  logic [NDUT-1:0] err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : (g == 3) ? 15 : 4;
    wb_byte_ram #(.ADDR_WIDTH(10), .LATENCY(L), .INIT_FILE("")) u_dut (
      .i_clk     (clk),
      .i_reset_n (rstn[g]),
      .i_wb_stb  (stb[g]),
      .i_wb_we   (wb_we),
      .i_wb_addr (wb_addr),
      .i_wb_sel  (wb_sel),
      .i_wb_data (wb_wdata),
      .o_wb_data (rd[g]),
      .o_wb_ack  (ack[g]),
      .o_wb_stall(stall[g])
`ifdef WB_RAM_ERR_EN
      ,
      .o_wb_err  (err[g])
`endif
    );
  end

  typedef struct {
    string       name;
    int          k;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        poke;
    logic        chk_data;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic int lat_of(input int k);
    case (k)
      0: return 1;
      1: return 0;
      2: return 3;
      3: return 15;
      default: return 4;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic add(input string name, input int k, input logic we, input logic [31:0] addr,
                     input logic [3:0] sel, input logic [31:0] wdata, input logic poke,
                     input logic chk_data, input logic [31:0] exp_data, input logic exp_err);
    vec_t v;
    v.name = name; v.k = k; v.we = we; v.addr = addr; v.sel = sel; v.wdata = wdata;
    v.poke = poke; v.chk_data = chk_data; v.exp_data = exp_data; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  // One transaction: checks ack/err cycle, ack count, stall length and data.
  task automatic run(input vec_t v);
    int lat, ack_at, err_at, n_ack, n_stall;
    logic [31:0] got;
    lat = lat_of(v.k);
    ack_at = -1; err_at = -1; n_ack = 0; n_stall = 0; got = '0;
    @(negedge clk);
    wb_we = v.we; wb_addr = v.addr; wb_sel = v.sel; wb_wdata = v.wdata;
    stb[v.k] = 1'b1;
    @(posedge clk); #1;
    stb[v.k] = 1'b0;
    for (int c = 1; c <= lat + 3; c++) begin
      if (v.poke && c == 1) stb[v.k] = 1'b1;
      if (c == 2) stb[v.k] = 1'b0;
      if (stall[v.k]) n_stall++;
      if (ack[v.k]) begin
        n_ack++;
        if (ack_at < 0) ack_at = c;
        got = rd[v.k];
      end
`ifdef WB_RAM_ERR_EN
      if (err[v.k]) begin
        if (err_at < 0) err_at = c;
        got = rd[v.k];
      end
`endif
      @(posedge clk); #1;
    end
    chk({v.name, " ack_cycle"}, ack_at, v.exp_err ? -1 : lat + 1);
    chk({v.name, " ack_count"}, n_ack, v.exp_err ? 0 : 1);
    chk({v.name, " stall_cycles"}, n_stall, lat);
    if (v.chk_data) chk({v.name, " data"}, got, v.exp_data);
`ifdef WB_RAM_ERR_EN
    chk({v.name, " err_cycle"}, err_at, v.exp_err ? lat + 1 : -1);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n_ack;
    vec_t v;
    rstn = '0; stb = '0;
    wb_we = 1'b0; wb_addr = '0; wb_sel = '0; wb_wdata = '0;

    add("w5_full",   0, 1, 32'd5,     4'b1111, 32'hDEADBEEF, 0, 0, 32'h0,        0);
    add("r5_full",   0, 0, 32'd5,     4'b0000, 32'h0,        0, 1, 32'hDEADBEEF, 0);
    add("w5_lane2",  0, 1, 32'd5,     4'b0100, 32'h00A50000, 0, 1, 32'hDEADBEEF, 0);
    add("r5_lane2",  0, 0, 32'd5,     4'b1111, 32'h0,        0, 1, 32'hDEA5BEEF, 0);
    add("w5_nosel",  0, 1, 32'd5,     4'b0000, 32'h0,        0, 0, 32'h0,        0);
    add("r5_nosel",  0, 0, 32'd5,     4'b0001, 32'h0,        0, 1, 32'hDEA5BEEF, 0);
    add("w0",        0, 1, 32'd0,     4'b1111, 32'hCAFEF00D, 0, 0, 32'h0,        0);
`ifdef WB_RAM_ERR_EN
    add("r400_oor",  0, 0, 32'h400,   4'b1111, 32'h0,        0, 1, 32'hDEA5BEEF, 1);
    add("w405_oor",  0, 1, 32'h405,   4'b1111, 32'h11111111, 0, 0, 32'h0,        1);
    add("r5_after",  0, 0, 32'd5,     4'b1111, 32'h0,        0, 1, 32'hDEA5BEEF, 0);
`else
    add("r400_alias",0, 0, 32'h400,   4'b1111, 32'h0,        0, 1, 32'hCAFEF00D, 0);
    add("w405_alias",0, 1, 32'h405,   4'b1111, 32'h11111111, 0, 0, 32'h0,        0);
    add("r5_after",  0, 0, 32'd5,     4'b1111, 32'h0,        0, 1, 32'h11111111, 0);
`endif
    add("l0_w9",     1, 1, 32'd9,     4'b1111, 32'hAAAA5555, 0, 0, 32'h0,        0);
    add("l0_r9",     1, 0, 32'd9,     4'b1111, 32'h0,        0, 1, 32'hAAAA5555, 0);
    add("l3_w1",     2, 1, 32'd1,     4'b1111, 32'h33333333, 1, 0, 32'h0,        0);
    add("l3_r1",     2, 0, 32'd1,     4'b1111, 32'h0,        1, 1, 32'h33333333, 0);
    add("l15_w2",    3, 1, 32'd2,     4'b1111, 32'hF00F0FF0, 1, 0, 32'h0,        0);
    add("l15_r2",    3, 0, 32'd2,     4'b1111, 32'h0,        1, 1, 32'hF00F0FF0, 0);
    add("l4_w7_zero",4, 1, 32'd7,     4'b1111, 32'h0,        0, 0, 32'h0,        0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset ack", {31'd0, ack[0]}, 32'd0);
    chk("reset stall", {31'd0, stall[0]}, 32'd0);
    chk("reset data", rd[0], 32'h0);
`ifdef WB_RAM_ERR_EN
    chk("reset err", {31'd0, err[0]}, 32'd0);
`endif
    @(negedge clk);
    rstn = '1;

    foreach (vecs[i]) run(vecs[i]);

    // Back-to-back at zero latency: four writes then four reads, one per cycle.
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      wb_we = (i < 4); wb_addr = 32'(i % 4); wb_sel = 4'hF;
      wb_wdata = 32'hB0000000 + 32'(i);
      stb[1] = 1'b1;
      @(posedge clk); #1;
      chk("b2b ack", {31'd0, ack[1]}, 32'd1);
      chk("b2b stall", {31'd0, stall[1]}, 32'd0);
      if (i >= 4) chk("b2b data", rd[1], 32'hB0000000 + 32'(i - 4));
      @(negedge clk);
    end
    stb[1] = 1'b0;
    @(posedge clk); #1;
    chk("b2b idle ack", {31'd0, ack[1]}, 32'd0);

    // Reset two cycles into a LATENCY=4 write: no ack, memory untouched.
    @(negedge clk);
    wb_we = 1'b1; wb_addr = 32'd7; wb_sel = 4'hF; wb_wdata = 32'h12345678;
    stb[4] = 1'b1;
    @(posedge clk); #1;
    stb[4] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn[4] = 1'b0;
    #1;
    chk("midrst stall", {31'd0, stall[4]}, 32'd0);
    n_ack = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ack[4]) n_ack++;
    end
    @(negedge clk);
    rstn[4] = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack[4]) n_ack++;
    end
    chk("midrst acks", n_ack, 0);
    v.name = "midrst_r7"; v.k = 4; v.we = 1'b0; v.addr = 32'd7; v.sel = 4'hF;
    v.wdata = '0; v.poke = 1'b0; v.chk_data = 1'b1; v.exp_data = 32'h0; v.exp_err = 1'b0;
    run(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
